// File: rtl/ram_access_ctrl.sv
// Shares one synchronous RAM port between a manual requester, a background display scanner
// and a bulk clear engine. Every access takes three cycles: issue, RAM sample, capture.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned SCAN_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              man_req,
  input  logic              man_we,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic [DATA_W-1:0] man_wdata,
  output logic              man_gnt,
  output logic [DATA_W-1:0] man_rdata,
  output logic              man_rvalid,
  input  logic              clr_start,
  output logic              busy,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {StIdle, StAcc, StRet, StClear} state_e;

  state_e              state_q, state_d;
  logic                clr_pend_q, clr_pend_d;
  logic                scan_pend_q, scan_pend_d;
  logic [ADDR_W-1:0]   scan_ptr_q, scan_ptr_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                cur_scan_q, cur_scan_d;
  logic                cur_we_q, cur_we_d;
  logic                man_gnt_q, man_gnt_d;
  logic [DATA_W-1:0]   man_rdata_q, man_rdata_d;
  logic                man_rvalid_q, man_rvalid_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
  logic [DATA_W-1:0]   scan_data_q, scan_data_d;
  logic                scan_valid_q, scan_valid_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ram_we_q, ram_we_d;
  logic                div_wrap;

  assign div_wrap = (div_q == DivW'(SCAN_DIV - 1));

  always_comb begin
    state_d      = state_q;
    clr_pend_d   = clr_pend_q;
    scan_pend_d  = scan_pend_q;
    scan_ptr_d   = scan_ptr_q;
    div_d        = div_wrap ? '0 : div_q + 1'b1;
    cur_scan_d   = cur_scan_q;
    cur_we_d     = cur_we_q;
    man_gnt_d    = 1'b0;
    man_rdata_d  = man_rdata_q;
    man_rvalid_d = 1'b0;
    busy_d       = busy_q;
    scan_addr_d  = scan_addr_q;
    scan_data_d  = scan_data_q;
    scan_valid_d = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = ram_we_q;

    // Ticks never queue: one pending scan at most.
    if (div_wrap && scan_en) scan_pend_d = 1'b1;
    if (clr_start && state_q != StClear) clr_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (clr_pend_q) begin
          state_d     = StClear;
          clr_pend_d  = 1'b0;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
          ram_we_d    = 1'b1;
          busy_d      = 1'b1;
        end else if (man_req) begin
          state_d     = StAcc;
          ram_addr_d  = man_addr;
          ram_wdata_d = man_wdata;
          ram_we_d    = man_we;
          man_gnt_d   = 1'b1;
          cur_scan_d  = 1'b0;
          cur_we_d    = man_we;
        end else if (scan_pend_q) begin
          state_d     = StAcc;
          scan_pend_d = 1'b0;
          ram_addr_d  = scan_ptr_q;
          ram_we_d    = 1'b0;
          cur_scan_d  = 1'b1;
          cur_we_d    = 1'b0;
        end
      end
      StAcc: begin
        state_d  = StRet;
        ram_we_d = 1'b0;
      end
      StRet: begin
        state_d = StIdle;
        if (cur_scan_q) begin
          scan_addr_d  = scan_ptr_q;
          scan_data_d  = ram_rdata;
          scan_valid_d = 1'b1;
          scan_ptr_d   = scan_ptr_q + 1'b1;
        end else if (!cur_we_q) begin
          man_rdata_d  = ram_rdata;
          man_rvalid_d = 1'b1;
        end
      end
      StClear: begin
        if (ram_addr_q == '1) begin
          state_d    = StIdle;
          ram_we_d   = 1'b0;
          busy_d     = 1'b0;
          scan_ptr_d = '0;
        end else begin
          ram_addr_d = ram_addr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clr_pend_q   <= 1'b0;
      scan_pend_q  <= 1'b0;
      scan_ptr_q   <= '0;
      div_q        <= '0;
      cur_scan_q   <= 1'b0;
      cur_we_q     <= 1'b0;
      man_gnt_q    <= 1'b0;
      man_rdata_q  <= '0;
      man_rvalid_q <= 1'b0;
      busy_q       <= 1'b0;
      scan_addr_q  <= '0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_pend_q   <= clr_pend_d;
      scan_pend_q  <= scan_pend_d;
      scan_ptr_q   <= scan_ptr_d;
      div_q        <= div_d;
      cur_scan_q   <= cur_scan_d;
      cur_we_q     <= cur_we_d;
      man_gnt_q    <= man_gnt_d;
      man_rdata_q  <= man_rdata_d;
      man_rvalid_q <= man_rvalid_d;
      busy_q       <= busy_d;
      scan_addr_q  <= scan_addr_d;
      scan_data_q  <= scan_data_d;
      scan_valid_q <= scan_valid_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
    end
  end

  assign man_gnt    = man_gnt_q;
  assign man_rdata  = man_rdata_q;
  assign man_rvalid = man_rvalid_q;
  assign busy       = busy_q;
  assign scan_addr  = scan_addr_q;
  assign scan_data  = scan_data_q;
  assign scan_valid = scan_valid_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 32x4 synchronous RAM attached.
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       man_req = 1'b0, man_we = 1'b0;
  logic [4:0] man_addr = '0;
  logic [3:0] man_wdata = '0;
  logic       man_gnt, man_rvalid;
  logic [3:0] man_rdata;
  logic       clr_start = 1'b0, busy;
  logic       scan_en = 1'b0, scan_valid;
  logic [4:0] scan_addr, ram_addr;
  logic [3:0] scan_data, ram_wdata, ram_rdata;
  logic       ram_we;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [3:0] last_rd = '0;

  // RAM model, with a side port so the bench can preload contents while the DUT is idle.
  logic [3:0] mem [32];
  logic       ld_en = 1'b0;
  logic [4:0] ld_addr = '0;
  logic [3:0] ld_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
    ram_rdata <= mem[ram_addr];
  end

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .man_req    (man_req),
    .man_we     (man_we),
    .man_addr   (man_addr),
    .man_wdata  (man_wdata),
    .man_gnt    (man_gnt),
    .man_rdata  (man_rdata),
    .man_rvalid (man_rvalid),
    .clr_start  (clr_start),
    .busy       (busy),
    .scan_en    (scan_en),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {5'd0, man_gnt, man_rdata, man_rvalid, busy, scan_addr, scan_data, scan_valid,
            ram_addr, ram_wdata, ram_we};
  endfunction

  task automatic poke(input logic [4:0] a, input logic [3:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic man_access(input logic we, input logic [4:0] a, input logic [3:0] wd,
                            input logic [3:0] exp);
    int waited = 0;
    logic got = 1'b0;
    @(negedge clk);
    man_req = 1'b1; man_we = we; man_addr = a; man_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (man_gnt) begin got = 1'b1; break; end
      waited++;
    end
    check("gnt_seen", 32'(got), 32'd1);
    if (!got) begin man_req = 1'b0; return; end
    check("gnt_wait", waited, 0);
    check("acc_addr", 32'(ram_addr), 32'(a));
    check("acc_we", 32'(ram_we), 32'(we));
    if (we) check("acc_wdata", 32'(ram_wdata), 32'(wd));
    man_req = 1'b0;
    @(posedge clk); #1;
    check("gnt_one_cycle", {man_gnt, ram_we}, 32'd0);
    @(posedge clk); #1;
    check("rvalid", 32'(man_rvalid), 32'(!we));
    if (!we) begin
      check("rdata", 32'(man_rdata), 32'(exp));
      last_rd = exp;
    end else begin
      check("rdata_hold", 32'(man_rdata), 32'(last_rd));
    end
  endtask

  task automatic wait_busy(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busy) begin seen = 1'b1; break; end
    end
    check("busy_rise", 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic       seen;
    int         t_prev, n, w;
    logic       saw;
    logic [9:0] gv;

    vecs[0] = '{1'b1, 5'd5,  4'hA, 4'h0};
    vecs[1] = '{1'b0, 5'd5,  4'h0, 4'hA};
    vecs[2] = '{1'b1, 5'd0,  4'h3, 4'h0};
    vecs[3] = '{1'b1, 5'd31, 4'hF, 4'h0};
    vecs[4] = '{1'b0, 5'd0,  4'h0, 4'h3};
    vecs[5] = '{1'b0, 5'd31, 4'h0, 4'hF};
    vecs[6] = '{1'b1, 5'd20, 4'h6, 4'h0};
    vecs[7] = '{1'b1, 5'd10, 4'hC, 4'h0};
    vecs[8] = '{1'b0, 5'd20, 4'h0, 4'h6};
    vecs[9] = '{1'b0, 5'd10, 4'h0, 4'hC};

    repeat (3) @(posedge clk);
    #1 check("reset_outputs", all_outs(), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++)
      man_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Bulk clear: 32 consecutive zero writes, addresses in order.
    @(negedge clk) clr_start = 1'b1;
    @(negedge clk) clr_start = 1'b0;
    wait_busy(seen);
    for (int i = 0; i < 32; i++) begin
      check("clear_step", {busy, ram_we, ram_wdata, ram_addr}, {21'd0, 1'b1, 1'b1, 4'h0, 5'(i)});
      @(posedge clk); #1;
    end
    check("clear_end", {busy, ram_we}, 32'd0);
    man_access(1'b0, 5'd0, 4'h0, 4'h0);
    man_access(1'b0, 5'd31, 4'h0, 4'h0);

    // Scanner: preload data = addr[3:0], expect a pulse every 4 cycles and a 31->0 wrap.
    for (int i = 0; i < 32; i++) poke(5'(i), 4'(i));
    @(negedge clk) scan_en = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 34; k++) begin
      saw = 1'b0;
      for (int j = 0; j < 10; j++) begin
        @(posedge clk); #1;
        if (scan_valid) begin saw = 1'b1; break; end
      end
      check("scan_seen", 32'(saw), 32'd1);
      check("scan_addr", 32'(scan_addr), 32'(k % 32));
      check("scan_data", 32'(scan_data), 32'((k % 32) % 16));
      if (k > 0) check("scan_period", cyc - t_prev, 4);
      t_prev = cyc;
    end

    // Manual beats a pending scan; a clear raised mid-access runs next; scan restarts at 0.
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (scan_valid) break;
    end
    @(posedge clk); #1;
    scan_en = 1'b0;
    man_req = 1'b1; man_we = 1'b0; man_addr = 5'd7;
    @(posedge clk); #1;
    check("prio_gnt", {man_gnt, ram_addr}, {26'd0, 1'b1, 5'd7});
    man_req = 1'b0; clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    @(posedge clk); #1;
    check("prio_read", {man_rvalid, man_rdata, busy}, {26'd0, 1'b1, 4'h7, 1'b0});
    last_rd = 4'h7;
    @(posedge clk); #1;
    check("prio_clear_start", {busy, ram_addr}, {26'd0, 1'b1, 5'd0});
    n = 1; saw = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (scan_valid) saw = 1'b1;
      if (!busy) break;
      n++;
    end
    check("prio_busy_len", n, 32);
    check("prio_no_scan_in_clear", 32'(saw), 32'd0);
    w = 0; saw = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      w++;
      if (scan_valid) begin saw = 1'b1; break; end
    end
    check("prio_scan_after", {saw, w[7:0]}, {23'd0, 1'b1, 8'd3});
    check("prio_scan_ptr0", {scan_addr, scan_data}, 32'd0);

    // Held request: one grant per 3-cycle transaction.
    repeat (4) @(posedge clk);
    @(negedge clk);
    man_req = 1'b1; man_we = 1'b0; man_addr = 5'd3;
    gv = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      gv[c] = man_gnt;
    end
    man_req = 1'b0;
    check("hold_gnt_pattern", 32'(gv), 32'b1001001001);
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (man_gnt) saw = 1'b1;
    end
    check("hold_no_extra_gnt", 32'(saw), 32'd0);
    last_rd = 4'h3;

    // Reset during clear at address 10: partial clear persists.
    for (int i = 0; i <= 10; i++) poke(5'(i), 4'h5);
    poke(5'd20, 4'h9);
    @(negedge clk) clr_start = 1'b1;
    @(negedge clk) clr_start = 1'b0;
    wait_busy(seen);
    saw = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (ram_addr == 5'd10) begin saw = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rst_reach_addr10", 32'(saw), 32'd1);
    rst_n = 1'b0;
    #1 check("rst_async_outputs", all_outs(), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    last_rd = 4'h0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) man_access(1'b0, 5'(i), 4'h0, 4'h0);
    man_access(1'b0, 5'd10, 4'h0, 4'h5);
    man_access(1'b0, 5'd20, 4'h0, 4'h9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
